// File: rtl/obstacle_pkg.sv
// Shared obstacle table layout, slot count and scheduler state encoding.
// The track draw block imports obstacle_t so both sides agree on the packing.
package obstacle_pkg;
  localparam int NUM_OBSTACLES = 10;
  localparam int TYPE_W        = 2;
  localparam int POS_W         = 10;
  localparam int LANE_W        = 2;
  localparam int TYPE_LSB      = 13;
  localparam int POS_LSB       = 3;
  localparam int LANE_LSB      = 1;
  localparam int ACTIVE_BIT    = 0;
  localparam int SLOT_W        = $clog2(NUM_OBSTACLES);

  typedef struct packed {
    logic [TYPE_W-1:0] obs_type;
    logic [POS_W-1:0]  position;
    logic [LANE_W-1:0] lane;
    logic              active;
  } obstacle_t;

  typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_SPAWN} state_t;

  // Only three lanes exist, so the fourth raw code folds onto the middle lane.
  function automatic logic [LANE_W-1:0] lane_map(input logic [1:0] raw);
    return (raw == 2'd3) ? 2'd1 : raw;
  endfunction
endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16/14/13/11; steps only when advance is high.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= SEED;
    end else if (advance) begin
      value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
    end
  end
endmodule

// File: rtl/obstacle_scheduler.sv
// Per-frame obstacle table update: scroll/retire one slot per cycle, then an
// interval-gated spawn into the lowest free slot.
module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter logic [POS_W-1:0] SPAWN_X   = 10'd1023,
  parameter logic [15:0]      LFSR_SEED = 16'hACE1
) (
  input  logic       system_clock_in,
  input  logic       reset_in,
  input  logic       vsync,
  input  logic       enable,
  input  logic       clear,
  input  logic [3:0] speed,
  input  logic [7:0] spawn_interval,
  output obstacle_t  obstacles [NUM_OBSTACLES],
  output logic       busy,
  output logic       spawned,
  output logic       spawn_dropped,
  output logic       overrun
);
  state_t            state;
  logic [SLOT_W-1:0] slot;
  logic [7:0]        frame_cnt;
  logic              vsync_q;
  logic              tick;
  logic              spawn_due;
  logic              free_found;
  logic [SLOT_W-1:0] free_slot;
  logic [15:0]       lfsr_value;
  obstacle_t         cur;

  assign tick      = vsync & ~vsync_q;
  assign cur       = obstacles[slot];
  assign spawn_due = (spawn_interval != 8'd0) &&
                     (({1'b0, frame_cnt} + 9'd1) >= {1'b0, spawn_interval});

  // Lowest-index inactive slot wins; scanning downward leaves the lowest last.
  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = NUM_OBSTACLES - 1; i >= 0; i--) begin
      if (!obstacles[i].active) begin
        free_found = 1'b1;
        free_slot  = SLOT_W'(i);
      end
    end
  end

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock   (system_clock_in),
    .reset   (reset_in),
    .advance (state == ST_SPAWN && !clear && spawn_due),
    .value   (lfsr_value)
  );

  always_ff @(posedge system_clock_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUM_OBSTACLES; i++) obstacles[i] <= '0;
      state         <= ST_IDLE;
      slot          <= '0;
      frame_cnt     <= '0;
      vsync_q       <= 1'b0;
      busy          <= 1'b0;
      spawned       <= 1'b0;
      spawn_dropped <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      vsync_q       <= vsync;
      spawned       <= 1'b0;
      spawn_dropped <= 1'b0;
      overrun       <= 1'b0;
      if (clear) begin
        for (int i = 0; i < NUM_OBSTACLES; i++) obstacles[i] <= '0;
        state     <= ST_IDLE;
        slot      <= '0;
        frame_cnt <= '0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (tick && enable) begin
              state <= ST_MOVE;
              slot  <= '0;
              busy  <= 1'b1;
            end
          end
          ST_MOVE: begin
            overrun <= tick;
            if (cur.active) begin
              if (cur.position < POS_W'(speed)) begin
                obstacles[slot] <= '0;
              end else begin
                obstacles[slot].position <= cur.position - POS_W'(speed);
              end
            end
            if (slot == SLOT_W'(NUM_OBSTACLES - 1)) begin
              state <= ST_SPAWN;
            end else begin
              slot <= slot + 1'b1;
            end
          end
          ST_SPAWN: begin
            overrun <= tick;
            if (spawn_due) begin
              frame_cnt <= '0;
              if (free_found) begin
                obstacles[free_slot] <= '{obs_type: lfsr_value[3:2], position: SPAWN_X,
                                          lane: lane_map(lfsr_value[1:0]), active: 1'b1};
                spawned <= 1'b1;
              end else begin
                spawn_dropped <= 1'b1;
              end
            end else if (spawn_interval != 8'd0) begin
              frame_cnt <= frame_cnt + 8'd1;
            end else begin
              frame_cnt <= '0;
            end
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_obstacle_scheduler.sv
// Randomised frame-level bench for obstacle_scheduler against a table model.
module tb_obstacle_scheduler;
  import obstacle_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync, enable, clear;
  logic [3:0] speed;
  logic [7:0] spawn_interval;
  obstacle_t  obstacles [NUM_OBSTACLES];
  logic       busy, spawned, spawn_dropped, overrun;

  int checks = 0;
  int errors = 0;

  obstacle_t   m_tab [NUM_OBSTACLES];
  int          m_cnt;
  logic [15:0] m_lfsr;

  obstacle_scheduler dut (
    .system_clock_in (clk),
    .reset_in        (rst),
    .vsync           (vsync),
    .enable          (enable),
    .clear           (clear),
    .speed           (speed),
    .spawn_interval  (spawn_interval),
    .obstacles       (obstacles),
    .busy            (busy),
    .spawned         (spawned),
    .spawn_dropped   (spawn_dropped),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_OBSTACLES; i++) m_tab[i] = '0;
    m_cnt = 0;
  endtask

  // One whole frame: scroll/retire every slot, then the interval-gated spawn.
  task automatic model_frame(input int spd, input int intv, output bit sp, output bit dr);
    int    pos;
    int    raw;
    bit    placed;
    sp = 0;
    dr = 0;
    for (int i = 0; i < NUM_OBSTACLES; i++) begin
      if (m_tab[i].active) begin
        pos = int'(m_tab[i].position);
        if (pos < spd) m_tab[i] = '0;
        else m_tab[i].position = 10'(pos - spd);
      end
    end
    if (intv == 0) begin
      m_cnt = 0;
    end else if (m_cnt + 1 >= intv) begin
      m_cnt  = 0;
      placed = 0;
      for (int i = 0; i < NUM_OBSTACLES && !placed; i++) begin
        if (!m_tab[i].active) begin
          raw = int'(m_lfsr) % 4;
          m_tab[i].obs_type = 2'((int'(m_lfsr) / 4) % 4);
          m_tab[i].position = 10'd1023;
          m_tab[i].lane     = (raw == 3) ? 2'd1 : 2'(raw);
          m_tab[i].active   = 1'b1;
          placed = 1;
        end
      end
      sp = placed;
      dr = !placed;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  // Caller sits #1 after a posedge with vsync low; the tick cycle starts here.
  task automatic run_frame(input string tag, input bit drop_enable);
    bit esp, edr;
    int n;
    model_frame(int'(speed), int'(spawn_interval), esp, edr);
    vsync = 1'b1;
    step();
    if (drop_enable) enable = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    checks++;
    if (n != NUM_OBSTACLES + 1) begin
      errors++;
      $display("FAIL %s busy_len got %0d want %0d", tag, n, NUM_OBSTACLES + 1);
    end
    checks++;
    if (spawned !== esp || spawn_dropped !== edr) begin
      errors++;
      $display("FAIL %s pulses got sp=%b dr=%b want sp=%b dr=%b", tag, spawned, spawn_dropped, esp, edr);
    end
    for (int i = 0; i < NUM_OBSTACLES; i++) begin
      checks++;
      if (obstacles[i] !== m_tab[i]) begin
        errors++;
        $display("FAIL %s slot%0d got %h want %h", tag, i, obstacles[i], m_tab[i]);
      end
    end
    vsync  = 1'b0;
    enable = 1'b1;
    step();
    checks++;
    if (spawned !== 1'b0 || spawn_dropped !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse_width got sp=%b dr=%b ov=%b want 000", tag, spawned, spawn_dropped, overrun);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || spawned !== 1'b0 || spawn_dropped !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got %b%b%b%b want 0000", busy, spawned, spawn_dropped, overrun);
    end
    for (int i = 0; i < NUM_OBSTACLES; i++) begin
      checks++;
      if (obstacles[i] !== 15'd0) begin
        errors++;
        $display("FAIL reset_slot%0d got %h want 0000", i, obstacles[i]);
      end
    end
    rst = 1'b0;
    step();
    model_clear();
    m_lfsr = 16'hACE1;
  endtask

  task automatic test_first_spawn();
    speed = 4'd0;
    spawn_interval = 8'd1;
    run_frame("first_spawn", 1'b0);
    checks++;
    if (obstacles[0].position !== 10'd1023 || obstacles[0].active !== 1'b1) begin
      errors++;
      $display("FAIL first_spawn_pos got %h want pos 3ff active", obstacles[0]);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 40; f++) begin
      speed = 4'($urandom_range(0, 15));
      spawn_interval = 8'($urandom_range(0, 3));
      run_frame("random", bit'($urandom_range(0, 1)));
      for (int i = 0; i < NUM_OBSTACLES; i++) begin
        if (obstacles[i].active === 1'b1) begin
          checks++;
          if (obstacles[i].lane === 2'd3) begin
            errors++;
            $display("FAIL random_lane slot%0d got 3 want 0..2", i);
          end
        end
      end
    end
  endtask

  task automatic test_fill_and_drop();
    do_clear();
    speed = 4'd0;
    spawn_interval = 8'd1;
    for (int f = 0; f < NUM_OBSTACLES + 1; f++) run_frame("fill", 1'b0);
    spawn_interval = 8'd2;
    run_frame("drop_cnt1", 1'b0);
    run_frame("drop_cnt2", 1'b0);
    do_clear();
    spawn_interval = 8'd3;
    for (int f = 0; f < 9; f++) run_frame("interval3", 1'b0);
  endtask

  task automatic test_retire_boundary();
    do_clear();
    speed = 4'd0;
    spawn_interval = 8'd1;
    run_frame("retire_seed", 1'b0);
    speed = 4'd15;
    spawn_interval = 8'd0;
    for (int f = 0; f < 69; f++) run_frame("retire", 1'b0);
    checks++;
    if (obstacles[0] !== 15'd0) begin
      errors++;
      $display("FAIL retire_final got %h want 0000", obstacles[0]);
    end
  endtask

  task automatic test_overrun();
    bit esp, edr;
    int ov;
    speed = 4'd3;
    spawn_interval = 8'd1;
    model_frame(3, 1, esp, edr);
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    ov = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (overrun === 1'b1) ov++;
    end
    checks++;
    if (ov != 1) begin
      errors++;
      $display("FAIL overrun_count got %0d want 1", ov);
    end
    for (int i = 0; i < NUM_OBSTACLES; i++) begin
      checks++;
      if (obstacles[i] !== m_tab[i]) begin
        errors++;
        $display("FAIL overrun_slot%0d got %h want %h", i, obstacles[i], m_tab[i]);
      end
    end
    vsync = 1'b0;
    step();
  endtask

  task automatic test_clear_mid_move();
    int bz;
    speed = 4'd2;
    spawn_interval = 8'd1;
    vsync = 1'b1;
    for (int c = 0; c < 5; c++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    vsync = 1'b0;
    model_clear();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_busy got %b want 0", busy);
    end
    for (int i = 0; i < NUM_OBSTACLES; i++) begin
      checks++;
      if (obstacles[i] !== 15'd0) begin
        errors++;
        $display("FAIL clear_slot%0d got %h want 0000", i, obstacles[i]);
      end
    end
    step();
    // A tick coinciding with clear must not start a frame.
    vsync = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    bz = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (busy === 1'b1) bz++;
    end
    checks++;
    if (bz != 0) begin
      errors++;
      $display("FAIL clear_tick busy_cycles got %0d want 0", bz);
    end
    vsync = 1'b0;
    step();
    run_frame("after_clear", 1'b0);
  endtask

  task automatic test_enable_low();
    int bz;
    enable = 1'b0;
    speed = 4'd5;
    spawn_interval = 8'd1;
    bz = 0;
    for (int p = 0; p < 4; p++) begin
      vsync = 1'b1;
      step();
      if (busy === 1'b1) bz++;
      step();
      vsync = 1'b0;
      step();
    end
    checks++;
    if (bz != 0) begin
      errors++;
      $display("FAIL enable_low busy_cycles got %0d want 0", bz);
    end
    for (int i = 0; i < NUM_OBSTACLES; i++) begin
      checks++;
      if (obstacles[i] !== m_tab[i]) begin
        errors++;
        $display("FAIL enable_low_slot%0d got %h want %h", i, obstacles[i], m_tab[i]);
      end
    end
    enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    vsync = 1'b0;
    enable = 1'b1;
    clear = 1'b0;
    speed = 4'd0;
    spawn_interval = 8'd0;
    test_reset();
    test_first_spawn();
    test_random_frames();
    test_fill_and_drop();
    test_retire_boundary();
    test_overrun();
    test_clear_mid_move();
    test_enable_low();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
